// File: rtl/led_seq_pkg.sv
// led_seq_pkg: CSR word addresses, CTRL/STATUS bit positions and FSM states for led_pattern_sequencer
package led_seq_pkg;
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_PATWR  = 3'd3;
  localparam logic [2:0] ADDR_LENGTH = 3'd4;
  localparam logic [2:0] ADDR_PTRRST = 3'd5;
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
endpackage

// File: rtl/led_seq_patmem.sv
// led_seq_patmem: DEPTH x LED_W pattern store, one synchronous write port, one asynchronous read port
module led_seq_patmem #(
  parameter int DEPTH = 16,
  parameter int LED_W = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LED_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [LED_W-1:0] rdata
);
  logic [LED_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: CSR-loaded LED pattern player replaying timed Avalon-MM writes to the PIO.
// Defining LED_PATTERN_SEQUENCER_IRQ_EN adds the irq output and the CTRL irq-enable bit.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LED_W = 9,
  parameter int PER_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  state_t state, state_d;
  logic run, loop, irq_en, done;
  logic [PER_W-1:0] period, per_eff, cnt;
  logic [LW-1:0] len;
  logic [AW-1:0] wr_ptr, step, step_d;
  logic [LED_W-1:0] pat, mem_rd;
  logic [31:0] ctrl_rd, stat_rd;
  logic wr, ctrl_wr, start, stop, last, tick, fin;
  assign wr      = chipselect && !write_n;
  assign ctrl_wr = wr && address == ADDR_CTRL;
  assign start   = ctrl_wr && writedata[CTRL_RUN];
  // a RUN=0 write in the same cycle counts as a stop request immediately
  assign stop    = ctrl_wr ? !writedata[CTRL_RUN] : !run;
  assign last    = {1'b0, step} == len - LW'(1);
  assign tick    = cnt == PER_W'(1);
  assign fin     = state == HOLD && !stop && tick && last && !loop;
  assign per_eff = period == '0 ? PER_W'(1) : period;
  led_seq_patmem #(.DEPTH(DEPTH), .LED_W(LED_W), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr && address == ADDR_PATWR),
    .waddr (wr_ptr),
    .wdata (writedata[LED_W-1:0]),
    .raddr (step_d),
    .rdata (mem_rd)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    step_d  = step;
    case (state)
      IDLE:  if (start) begin
        state_d = ISSUE;
        step_d  = '0;
      end
      ISSUE: if (!avm_waitrequest) state_d = stop ? IDLE : HOLD;
      HOLD:  if (stop) state_d = IDLE;
      else if (tick) begin
        state_d = fin ? IDLE : ISSUE;
        step_d  = last ? '0 : step + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    avm_address   = '0;
    avm_write     = state == ISSUE;
    avm_writedata = avm_write ? 32'(pat) : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run    <= 1'b0;
      loop   <= 1'b0;
      done   <= 1'b0;
      period <= PER_W'(1);
      len    <= LW'(1);
      wr_ptr <= '0;
      step   <= '0;
      cnt    <= '0;
      pat    <= '0;
    end else begin
      run    <= fin ? 1'b0 : ctrl_wr ? writedata[CTRL_RUN] : run;
      loop   <= ctrl_wr ? writedata[CTRL_LOOP] : loop;
      done   <= fin || (done && !(wr && address == ADDR_STATUS));
      period <= wr && address == ADDR_PERIOD ? writedata[PER_W-1:0] : period;
      if (wr && address == ADDR_LENGTH)
        len <= writedata == '0 ? LW'(1) : writedata > 32'(DEPTH) ? LW'(DEPTH) : writedata[LW-1:0];
      wr_ptr <= wr && address == ADDR_PATWR ? wr_ptr + AW'(1) : wr && address == ADDR_PTRRST ? '0 : wr_ptr;
      step   <= step_d;
      // reloading through the whole ISSUE keeps PERIOD live up to acceptance
      cnt    <= state == ISSUE ? per_eff : cnt - PER_W'(1);
      // latching on ISSUE entry keeps the master data stable under waitrequest
      if (state_d == ISSUE && state != ISSUE) pat <= mem_rd;
    end
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) irq_en <= 1'b0;
    else irq_en <= ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
  assign irq = done && irq_en;
`else
  assign irq_en = 1'b0;
`endif
  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_RUN]    = run;
    ctrl_rd[CTRL_LOOP]   = loop;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
    stat_rd              = '0;
    stat_rd[STAT_BUSY]   = state != IDLE;
    stat_rd[STAT_DONE]   = done;
    stat_rd[15:8]        = 8'(step);
    readdata = address == ADDR_CTRL   ? ctrl_rd :
               address == ADDR_STATUS ? stat_rd :
               address == ADDR_PERIOD ? 32'(period) :
               address == ADDR_PATWR  ? 32'(wr_ptr) :
               address == ADDR_LENGTH ? 32'(len) : '0;
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: randomized self-checking bench; expected writes come from a pattern-list model.
// Build with LED_PATTERN_SEQUENCER_IRQ_EN defined to also exercise irq.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 0, reset_n = 0;
  logic [2:0] address = '0;
  logic chipselect = 0, write_n = 1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0] avm_address;
  logic avm_write;
  logic [31:0] avm_writedata;
  logic avm_waitrequest = 0;
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
  logic irq;
`endif
  int checks = 0, failures = 0, cyc = 0;
  logic [8:0] model_mem [DEPTH];
  int model_wp = 0;
  int n_acc = 0;
  int acc_val [64], acc_cyc [64], start_cyc [64];
  bit in_write = 0;
  int st_cyc = 0;
  logic [31:0] hold_val = '0;
  int forced_stall = 0;
  bit rand_stall = 0;

  led_pattern_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest)
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (forced_stall > 0) begin
      avm_waitrequest = 1;
      if (avm_write) forced_stall--;
    end else avm_waitrequest = rand_stall && $urandom_range(0, 2) == 0;
  end

  always @(negedge clk) if (avm_write) begin
    if (!in_write) begin
      in_write = 1;
      st_cyc = cyc;
      hold_val = avm_writedata;
      check("avm_addr", 32'(avm_address), 0);
    end else check("stable", avm_writedata, hold_val);
    if (!avm_waitrequest) begin
      if (n_acc < 64) begin
        acc_val[n_acc] = avm_writedata;
        acc_cyc[n_acc] = cyc;
        start_cyc[n_acc] = st_cyc;
      end
      n_acc++;
      in_write = 0;
    end
  end

  task automatic csr_wr(logic [2:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
    if (a == ADDR_PATWR) begin
      model_mem[model_wp] = d[8:0];
      model_wp = (model_wp + 1) % DEPTH;
    end
    if (a == ADDR_PTRRST) model_wp = 0;
  endtask

  task automatic csr_rd(logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1; write_n = 1;
    #1 d = readdata;
    chipselect = 0;
  endtask

  // a finished sequence goes idle PERIOD hold cycles after the last accepted write
  task automatic wait_idle(int ep, int limit);
    logic [31:0] st;
    st = '0;
    for (int i = 0; i < limit; i++) begin
      csr_rd(ADDR_STATUS, st);
      if (!st[STAT_BUSY]) begin
        if (n_acc > 0) check("idle_time", cyc - acc_cyc[n_acc-1], ep + 1);
        return;
      end
    end
    check("busy_timeout", 32'(st[STAT_BUSY]), 0);
  endtask

  task automatic play(int per, int len, bit stall);
    int ep, el;
    logic [31:0] st;
    ep = per == 0 ? 1 : per;
    el = len == 0 ? 1 : len > DEPTH ? DEPTH : len;
    csr_wr(ADDR_PERIOD, per);
    csr_wr(ADDR_LENGTH, len);
    csr_wr(ADDR_STATUS, 0);
    n_acc = 0; in_write = 0; rand_stall = stall;
    csr_wr(ADDR_CTRL, 1);
    wait_idle(ep, 3000);
    rand_stall = 0;
    check("n_writes", n_acc, el);
    for (int i = 0; i < el && i < n_acc && i < 64; i++) begin
      check($sformatf("pat%0d", i), acc_val[i], 32'(model_mem[i]));
      if (i > 0) check($sformatf("gap%0d", i), start_cyc[i] - acc_cyc[i-1], ep + 1);
    end
    csr_rd(ADDR_STATUS, st);
    check("done_idle", 32'(st[1:0]), 2);
    repeat (5) @(posedge clk);
    check("quiet", n_acc, el);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #3 reset_n = 1;
    check("rst_avm_write", 32'(avm_write), 0);
    check("rst_avm_data", avm_writedata, 0);
    csr_rd(ADDR_CTRL, rd);   check("rst_ctrl", rd, 0);
    csr_rd(ADDR_STATUS, rd); check("rst_status", rd, 0);
    csr_rd(ADDR_PERIOD, rd); check("rst_period", rd, 1);
    csr_rd(ADDR_LENGTH, rd); check("rst_length", rd, 1);
    csr_rd(ADDR_PATWR, rd);  check("rst_wrptr", rd, 0);
    csr_rd(3'd6, rd);        check("unmapped", rd, 0);
    // three known patterns, then fill the rest of the memory
    csr_wr(ADDR_PATWR, 32'h001);
    csr_wr(ADDR_PATWR, 32'h0F0);
    csr_wr(ADDR_PATWR, 32'h1FF);
    csr_rd(ADDR_PATWR, rd); check("wrptr3", rd, 3);
    for (int i = 3; i < DEPTH; i++) csr_wr(ADDR_PATWR, $urandom);
    csr_rd(ADDR_PATWR, rd); check("wrptr_wrap", rd, model_wp);
    play(4, 3, 0);
    // loop then stop during HOLD
    csr_wr(ADDR_STATUS, 0);
    n_acc = 0; in_write = 0;
    csr_wr(ADDR_CTRL, 3);
    for (int i = 0; i < 500 && n_acc < 4; i++) @(negedge clk);
    csr_wr(ADDR_CTRL, 0);
    repeat (20) @(posedge clk);
    check("loop_n", n_acc, 4);
    check("loop_wrap", acc_val[3], 32'(model_mem[0]));
    check("loop_gap", start_cyc[3] - acc_cyc[2], 5);
    csr_rd(ADDR_STATUS, rd); check("stop_status", 32'(rd[1:0]), 0);
    // stalled first write
    forced_stall = 5;
    play(3, 2, 0);
    check("stall_len", acc_cyc[0] - start_cyc[0], 5);
    // degenerate and clamped settings
    play(0, 0, 0);
    play(2, 40, 0);
    // random content, timing and stalls
    for (int r = 0; r < 4; r++) begin
      csr_wr(ADDR_PTRRST, 0);
      for (int i = 0, k = $urandom_range(1, DEPTH); i < k; i++) csr_wr(ADDR_PATWR, $urandom);
      play($urandom_range(0, 5), $urandom_range(0, 20), 1);
    end
    // reset while a write is stalled
    forced_stall = 1000;
    csr_wr(ADDR_PERIOD, 2);
    csr_wr(ADDR_LENGTH, 3);
    csr_wr(ADDR_CTRL, 1);
    for (int i = 0; i < 50 && !avm_write; i++) @(negedge clk);
    @(negedge clk);
    check("stalled_write", 32'(avm_write), 1);
    reset_n = 0;
    #1;
    check("rst_async_write", 32'(avm_write), 0);
    check("rst_async_data", avm_writedata, 0);
    forced_stall = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    model_wp = 0; in_write = 0;
    csr_rd(ADDR_STATUS, rd); check("rst2_status", rd, 0);
    csr_rd(ADDR_PATWR, rd);  check("rst2_wrptr", rd, 0);
    csr_rd(ADDR_CTRL, rd);   check("rst2_ctrl", rd, 0);
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
    csr_wr(ADDR_PATWR, 32'h155);
    csr_wr(ADDR_PERIOD, 1);
    csr_wr(ADDR_LENGTH, 1);
    check("irq_idle", 32'(irq), 0);
    csr_wr(ADDR_CTRL, 5);
    rd = '0;
    for (int i = 0; i < 50 && !rd[STAT_DONE]; i++) begin
      csr_rd(ADDR_STATUS, rd);
      check("irq_track", 32'(irq), 32'(rd[STAT_DONE]));
    end
    check("irq_high", 32'(irq), 1);
    @(posedge clk);
    #1;
    address = ADDR_STATUS; writedata = 0; chipselect = 1; write_n = 0;
    @(negedge clk);
    check("irq_before_clr", 32'(irq), 1);
    @(posedge clk);
    #1;
    chipselect = 0; write_n = 1;
    check("irq_cleared", 32'(irq), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
